pdl_trig_cond: RTL

//  Trigger front end sitting directly upstream of pdl. Synchronises an asynchronous trigger, detects the selected edge,

---
 rtl/pdl_trig_cond.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/pdl_trig_cond.sv
// Trigger conditioner in front of pdl: synchronise, edge-detect, holdoff, and shadow wb/dl between triggers.
// Optional glitch filter on the synchronised level: define PDL_GLITCH_FILTER_EN.
module pdl_trig_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF_W   = 16,
    parameter int FILT_LEN    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 trig_in,
    input  logic [1:0]           edge_sel,
    input  logic [HOLDOFF_W-1:0] holdoff,
    input  logic [31:0]          wb_in,
    input  logic [31:0]          dl_in,
    input  logic                 cfg_load,
    output logic                 trig_out,
    output logic [31:0]          wb,
    output logic [31:0]          dl,
    output logic                 busy,
    output logic [15:0]          trig_cnt,
    output logic [7:0]           miss_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("pdl_trig_cond: SYNC_STAGES must be in 2..4");
    end
    if (FILT_LEN < 1) begin : g_bad_filt
        $error("pdl_trig_cond: FILT_LEN must be at least 1");
    end

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] syncChain_q;
    logic                   syncLvl;
    logic                   detLvl;
    logic                   prevLvl_q;
    logic                   riseDet;
    logic                   fallDet;
    logic                   edgeDet;
    logic                   fire;
    logic                   apply;
    logic                   miss;
    logic [HOLDOFF_W-1:0]   holdCnt_q, holdCnt_d;
    logic                   trig_q, trig_d;
    logic [31:0]            wb_q, wb_d;
    logic [31:0]            dl_q, dl_d;
    logic [31:0]            pendWb_q, pendWb_d;
    logic [31:0]            pendDl_q, pendDl_d;
    logic                   pendVld_q, pendVld_d;
    logic [15:0]            trigCnt_q, trigCnt_d;
    logic [7:0]             missCnt_q, missCnt_d;

    // The synchroniser and previous-level flop run regardless of state, so arming on a high line yields no edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            syncChain_q <= '0;
            prevLvl_q   <= 1'b0;
        end else begin
            syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], trig_in};
            prevLvl_q   <= detLvl;
        end
    end

    assign syncLvl = syncChain_q[SYNC_STAGES-1];

`ifdef PDL_GLITCH_FILTER_EN
    localparam int FCNT_W = $clog2(FILT_LEN + 1);

    logic [FCNT_W-1:0] filtCnt_q;
    logic              filtLvl_q;

    // The filtered level flips only once the synchronised level has disagreed with it FILT_LEN cycles in a row.
    always_ff @(posedge clk) begin
        if (!reset) begin
            filtCnt_q <= '0;
            filtLvl_q <= 1'b0;
        end else if (syncLvl != filtLvl_q) begin
            if (filtCnt_q == FCNT_W'(FILT_LEN - 1)) begin
                filtLvl_q <= syncLvl;
                filtCnt_q <= '0;
            end else begin
                filtCnt_q <= filtCnt_q + 1'b1;
            end
        end else begin
            filtCnt_q <= '0;
        end
    end

    assign detLvl = filtLvl_q;
`else
    assign detLvl = syncLvl;
`endif

    always_comb begin
        riseDet = detLvl & ~prevLvl_q;
        fallDet = ~detLvl & prevLvl_q;
        case (edge_sel)
            2'b00:   edgeDet = riseDet;
            2'b01:   edgeDet = fallDet;
            2'b10:   edgeDet = riseDet | fallDet;
            default: edgeDet = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (edgeDet) begin
                    state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (holdCnt_q == '0) begin
                    state_d = enable ? ST_ARMED : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == ST_HOLDOFF);
        trig_out = trig_q;
        wb       = wb_q;
        dl       = dl_q;
        trig_cnt = trigCnt_q;
        miss_cnt = missCnt_q;
    end

    // Pending config is only promoted in a quiet ARMED cycle, so wb/dl never move under a pulse or during holdoff.
    always_comb begin
        fire  = (state_q == ST_ARMED) && enable && edgeDet;
        apply = (state_q == ST_ARMED) && !edgeDet && pendVld_q;
        miss  = (state_q == ST_HOLDOFF) && edgeDet;

        trig_d    = fire;
        holdCnt_d = holdCnt_q;
        trigCnt_d = trigCnt_q;
        missCnt_d = missCnt_q;
        wb_d      = wb_q;
        dl_d      = dl_q;
        pendWb_d  = pendWb_q;
        pendDl_d  = pendDl_q;
        pendVld_d = pendVld_q;

        if (fire) begin
            holdCnt_d = holdoff;
            trigCnt_d = trigCnt_q + 16'd1;
        end else if (state_q == ST_HOLDOFF && holdCnt_q != '0) begin
            holdCnt_d = holdCnt_q - 1'b1;
        end

        if (miss && missCnt_q != 8'hFF) begin
            missCnt_d = missCnt_q + 8'd1;
        end

        if (apply) begin
            wb_d      = pendWb_q;
            dl_d      = pendDl_q;
            pendVld_d = 1'b0;
        end

        if (cfg_load) begin
            pendWb_d  = wb_in;
            pendDl_d  = dl_in;
            pendVld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            holdCnt_q <= '0;
            trig_q    <= 1'b0;
            trigCnt_q <= '0;
            missCnt_q <= '0;
            wb_q      <= '0;
            dl_q      <= '0;
            pendWb_q  <= '0;
            pendDl_q  <= '0;
            pendVld_q <= 1'b0;
        end else begin
            holdCnt_q <= holdCnt_d;
            trig_q    <= trig_d;
            trigCnt_q <= trigCnt_d;
            missCnt_q <= missCnt_d;
            wb_q      <= wb_d;
            dl_q      <= dl_d;
            pendWb_q  <= pendWb_d;
            pendDl_q  <= pendDl_d;
            pendVld_q <= pendVld_d;
        end
    end

endmodule
